load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage load/store unit of the 5-stage RV32I pipeline.
- Consumes the EX/MEM latch: load/store function code, ALU-computed effective address and store data.
- Drives a request/grant/response data-memory port and returns the aligned, sign/zero-extended load result to the MEM/WB latch.
- Stalls the pipeline while a memory transaction is outstanding; flags misaligned accesses and response timeouts.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the data port.
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT_RVALID before bus error; must be 1..255, 8-bit counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  EX/MEM holds a valid instruction
- lsu_func_i  in  4  load_store_func_code (NOP, LW, LH, LB, LHU, LBU, SW, SH, SB)
- addr_i  in  ADDR_WIDTH  effective byte address (ALU result)
- wdata_i  in  32  store data (rs2, post-forwarding)
- data_req_o  out  1  memory request
- data_we_o  out  1  1 = store
- data_be_o  out  4  byte enables
- data_addr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
- data_wdata_o  out  32  lane-replicated store data
- data_gnt_i  in  1  request accepted this cycle
- data_rvalid_i  in  1  response valid (loads and stores)
- data_rdata_i  in  32  raw read word
- stall_o  out  1  hold IF..MEM stages
- done_o  out  1  one-cycle pulse: access retired
- load_data_o  out  32  extended load result, valid with done_o on loads
- misaligned_o  out  1  one-cycle pulse: misaligned access, no request issued
- bus_error_o  out  1  one-cycle pulse: response timeout

Behaviour:
- Reset: state IDLE, timeout counter 0, latched request 0. All outputs 0 while rst_n = 0 and in IDLE with no valid access.
- Alignment checks:
  - LW/SW require addr[1:0] = 0.
  - LH/LHU/SH require addr[0] = 0.
  - Byte accesses are always aligned.
  - A misaligned access pulses misaligned_o combinationally in the same cycle. No request, no stall, state stays IDLE.
- Byte enables and store data:
  - SB: be = 0001 << addr[1:0], wdata = {4{wdata_i[7:0]}}.
  - SH: be = 0011 << addr[1:0], wdata = {2{wdata_i[15:0]}}.
  - SW: be = 1111, wdata = wdata_i.
  - Loads: we = 0, wdata = 0, be as for the same size.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE:
  - On valid_i and func != NOP and aligned: assert data_req_o combinationally from the inputs.
  - Latch func, addr[1:0], address, be, wdata into registers.
  - stall_o = 1.
  - If gnt = 1, go to WAIT_RVALID; else go to WAIT_GNT.
- WAIT_GNT:
  - Hold data_req_o = 1 with the latched address/we/be/wdata, unchanged until gnt.
  - stall_o = 1. On gnt, go to WAIT_RVALID.
- WAIT_RVALID:
  - data_req_o = 0. The counter increments each cycle.
  - On rvalid: done_o = 1, stall_o = 0 in that same cycle, load_data_o driven from rdata, return to IDLE, clear counter.
  - If rvalid is still absent with counter = TIMEOUT_CYCLES-1: bus_error_o = 1, stall_o = 0, load_data_o = 0, return to IDLE.
- Minimum access latency: 2 cycles (issue with gnt, then rvalid next cycle). A new access may issue in the cycle after done_o.
- Load extraction uses the latched offset:
  - LW: rdata.
  - LH/LHU: rdata[16*off[1]+:16], sign/zero-extended.
  - LB/LBU: rdata[8*off+:8], sign/zero-extended.
- Stores retire on rvalid with load_data_o = 0.
- Boundary conditions:
  - rvalid in IDLE or WAIT_GNT is ignored; a simulation assertion fires.
  - gnt with no req is ignored.
  - valid_i/addr_i changes while busy are ignored; the latched values are used.
  - rst_n asserted mid-transaction abandons it immediately with no pulses.
  - func = NOP with valid_i set: no action, done_o = 0.

Decomposition:
- Add to CORE_PKG:
  - lsu_state_e {LSU_IDLE, LSU_WAIT_GNT, LSU_WAIT_RVALID}.
  - Constant LSU_TIMEOUT_DEFAULT = 255.
- Reuse load_store_func_code from CORE_PKG.
- Sub-module lsu_load_align: combinational extraction and extension of (rdata, func, offset) into load_data. Unit-testable on its own.

Test Plan:
- LB addr 0x1003, rdata 0x80FF_FF12, gnt same cycle, rvalid next cycle -> load_data_o = 0xFFFF_FF80, done_o on cycle 2, stall_o high for 1 cycle only.
- LHU addr 0x2002, rdata 0xBEEF_1234 -> load_data_o = 0x0000_BEEF; LH same -> 0xFFFF_BEEF.
- SB addr 0x3001, wdata_i 0x0000_00AB, gnt delayed 3 cycles -> data_be_o = 0010, data_wdata_o = 0xABAB_ABAB, data_addr_o = 0x3000, req held stable 4 cycles, stall_o high until rvalid.
- LW addr 0x4002 -> misaligned_o pulse, data_req_o = 0, stall_o = 0; SH addr 0x4001 -> same response.
- LW granted, no rvalid, TIMEOUT_CYCLES = 4 -> bus_error_o pulses on the 4th WAIT_RVALID cycle, FSM back in IDLE, next LW proceeds normally.
- rst_n low during WAIT_GNT -> all outputs 0 immediately, FSM in IDLE after release, late gnt/rvalid ignored.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Shared types and helpers for the memory-stage load/store unit.
//   load_store_func_code : function code carried in the EX/MEM latch
//   lsu_state_e          : states of the LSU request/response FSM
//   lsu_size_e           : access width derived from the function code
//   LSU_TIMEOUT_DEFAULT  : default response timeout in WAIT_RVALID cycles
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package load_store_unit_pkg;

  typedef enum logic [3:0] {
    LSU_NOP = 4'd0,
    LSU_LW  = 4'd1,
    LSU_LH  = 4'd2,
    LSU_LB  = 4'd3,
    LSU_LHU = 4'd4,
    LSU_LBU = 4'd5,
    LSU_SW  = 4'd6,
    LSU_SH  = 4'd7,
    LSU_SB  = 4'd8
  } load_store_func_code;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WAIT_GNT,
    LSU_WAIT_RVALID
  } lsu_state_e;

  typedef enum logic [1:0] {
    LSU_SIZE_BYTE,
    LSU_SIZE_HALF,
    LSU_SIZE_WORD
  } lsu_size_e;

  localparam int LSU_TIMEOUT_DEFAULT = 255;

  // Codes outside the defined set behave as NOP so a corrupted latch never
  // produces a bus request.
  function automatic load_store_func_code lsu_decode(input logic [3:0] code);
    if (code <= 4'd8) begin
      lsu_decode = load_store_func_code'(code);
    end else begin
      lsu_decode = LSU_NOP;
    end
  endfunction

  function automatic lsu_size_e lsu_size(input load_store_func_code func);
    case (func)
      LSU_LW, LSU_SW:          lsu_size = LSU_SIZE_WORD;
      LSU_LH, LSU_LHU, LSU_SH: lsu_size = LSU_SIZE_HALF;
      default:                 lsu_size = LSU_SIZE_BYTE;
    endcase
  endfunction

  function automatic logic lsu_is_store(input load_store_func_code func);
    lsu_is_store = (func == LSU_SW) || (func == LSU_SH) || (func == LSU_SB);
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
// Combinational extraction of the addressed byte/halfword from a raw read
// word, followed by sign or zero extension according to the load type.
// Ports:
//   rdata     in  32  raw word returned by data memory
//   func      in  4   latched load_store_func_code
//   offset    in  2   latched byte offset (address bits [1:0])
//   load_data out 32  extended result; zero for stores and NOP
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [3:0]  func,
  input  logic [1:0]  offset,
  output logic [31:0] load_data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel  = rdata[{offset[1], 4'b0000} +: 16];
    byte_sel  = rdata[{offset, 3'b000} +: 8];
    load_data = '0;
    case (func)
      LSU_LW:  load_data = rdata;
      LSU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LSU_LHU: load_data = {16'h0000, half_sel};
      LSU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: load_data = {24'h000000, byte_sel};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Memory-stage load/store unit. Takes the EX/MEM access, issues it on a
// req/gnt/rvalid data port, stalls the pipeline while the access is in
// flight and returns the aligned, extended load result.
// Ports:
//   clk, rst_n         core clock, asynchronous active-low reset
//   valid_i            EX/MEM holds a valid instruction
//   lsu_func_i         load_store_func_code
//   addr_i             effective byte address
//   wdata_i            store data (rs2)
//   data_req_o         memory request
//   data_we_o          1 = store
//   data_be_o          byte enables
//   data_addr_o        word-aligned address
//   data_wdata_o       lane-replicated store data
//   data_gnt_i         request accepted this cycle
//   data_rvalid_i      response valid
//   data_rdata_i       raw read word
//   stall_o            hold IF..MEM stages
//   done_o             pulse: access retired
//   load_data_o        extended load result (valid with done_o)
//   misaligned_o       pulse: misaligned access, nothing issued
//   bus_error_o        pulse: response timeout
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [3:0]            lsu_func_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  data_req_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [31:0]           load_data_o,
  output logic                  misaligned_o,
  output logic                  bus_error_o
);

  // Counter value on the last WAIT_RVALID cycle before giving up.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e          state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                latch_en;

  load_store_func_code func_q;
  logic [1:0]          off_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]          be_q;
  logic [31:0]         wdata_q;
  logic                we_q;

  load_store_func_code func_in;
  lsu_size_e           size_in;
  logic                store_in;
  logic                aligned_in;
  logic [3:0]          be_in;
  logic [31:0]         wdata_in;
  logic [ADDR_WIDTH-1:0] addr_word_in;
  logic [31:0]         align_data;

  // Decode the incoming access: width, alignment, lane enables and the
  // replicated store word, all straight from the EX/MEM latch.
  always_comb begin
    func_in      = lsu_decode(lsu_func_i);
    size_in      = lsu_size(func_in);
    store_in     = lsu_is_store(func_in);
    addr_word_in = {addr_i[ADDR_WIDTH-1:2], 2'b00};
    aligned_in   = 1'b1;
    be_in        = 4'b1111;
    wdata_in     = wdata_i;
    case (size_in)
      LSU_SIZE_BYTE: begin
        aligned_in = 1'b1;
        be_in      = 4'b0001 << addr_i[1:0];
        wdata_in   = {4{wdata_i[7:0]}};
      end
      LSU_SIZE_HALF: begin
        aligned_in = ~addr_i[0];
        be_in      = 4'b0011 << addr_i[1:0];
        wdata_in   = {2{wdata_i[15:0]}};
      end
      default: begin
        aligned_in = (addr_i[1:0] == 2'b00);
        be_in      = 4'b1111;
        wdata_in   = wdata_i;
      end
    endcase
    if (!store_in) begin
      wdata_in = '0;
    end
  end

  lsu_load_align u_align (
    .rdata     (data_rdata_i),
    .func      (func_q),
    .offset    (off_q),
    .load_data (align_data)
  );

  // Next-state and output logic. Every output is forced low while reset is
  // asserted so an abandoned access leaves no trace on the port.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    latch_en     = 1'b0;
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = 4'b0000;
    data_addr_o  = '0;
    data_wdata_o = '0;
    stall_o      = 1'b0;
    done_o       = 1'b0;
    load_data_o  = '0;
    misaligned_o = 1'b0;
    bus_error_o  = 1'b0;
    if (rst_n) begin
      case (state_q)
        LSU_IDLE: begin
          if (valid_i && (func_in != LSU_NOP)) begin
            if (!aligned_in) begin
              misaligned_o = 1'b1;
            end else begin
              data_req_o   = 1'b1;
              data_we_o    = store_in;
              data_be_o    = be_in;
              data_addr_o  = addr_word_in;
              data_wdata_o = wdata_in;
              stall_o      = 1'b1;
              latch_en     = 1'b1;
              cnt_d        = 8'd0;
              state_d      = data_gnt_i ? LSU_WAIT_RVALID : LSU_WAIT_GNT;
            end
          end
        end
        LSU_WAIT_GNT: begin
          data_req_o   = 1'b1;
          data_we_o    = we_q;
          data_be_o    = be_q;
          data_addr_o  = addr_q;
          data_wdata_o = wdata_q;
          stall_o      = 1'b1;
          cnt_d        = 8'd0;
          if (data_gnt_i) begin
            state_d = LSU_WAIT_RVALID;
          end
        end
        LSU_WAIT_RVALID: begin
          // A response on the final counter value still wins over timeout.
          if (data_rvalid_i) begin
            done_o      = 1'b1;
            load_data_o = align_data;
            cnt_d       = 8'd0;
            state_d     = LSU_IDLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            bus_error_o = 1'b1;
            cnt_d       = 8'd0;
            state_d     = LSU_IDLE;
          end else begin
            stall_o = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = LSU_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // State, timeout counter and the latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      cnt_q   <= 8'd0;
      func_q  <= LSU_NOP;
      off_q   <= 2'b00;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        func_q  <= func_in;
        off_q   <= addr_i[1:0];
        addr_q  <= addr_word_in;
        be_q    <= be_in;
        wdata_q <= wdata_in;
        we_q    <= store_in;
      end
    end
  end

  // A response may only arrive while one is being waited for.
  rvalid_only_when_waiting: assert property (
    @(posedge clk) disable iff (!rst_n)
    data_rvalid_i |-> (state_q == LSU_WAIT_RVALID)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Scoreboard bench for load_store_unit: stimulus pushes the expected
// retirement of each access, a negedge monitor pops and compares, and a
// memory responder grants/answers requests and checks request contents.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int K_DONE  = 0;
  localparam int K_MIS   = 1;
  localparam int K_BERR  = 2;

  typedef struct {
    int          kind;
    logic [31:0] load_data;
    int          retire;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [3:0]  lsu_func_i = 4'd0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        stall_o;
  logic        done_o;
  logic [31:0] load_data_o;
  logic        misaligned_o;
  logic        bus_error_o;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_i       (valid_i),
    .lsu_func_i    (lsu_func_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .data_req_o    (data_req_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_addr_o   (data_addr_o),
    .data_wdata_o  (data_wdata_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i),
    .stall_o       (stall_o),
    .done_o        (done_o),
    .load_data_o   (load_data_o),
    .misaligned_o  (misaligned_o),
    .bus_error_o   (bus_error_o)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle = cycle + 1;

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  // Responder programming, written by the stimulus when an access is issued.
  bit          armed = 1'b0;
  bit          phase = 1'b0;
  bit          drop = 1'b0;
  int          gnt_left = 0;
  int          rv_left = 0;
  logic [31:0] arm_rdata = '0;
  logic [31:0] arm_addr = '0;
  logic [31:0] arm_wdata = '0;
  logic [3:0]  arm_be = '0;
  logic        arm_we = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [3:0] f);
    case (f)
      LSU_LW, LSU_SW:          size_of = 4;
      LSU_LH, LSU_LHU, LSU_SH: size_of = 2;
      default:                 size_of = 1;
    endcase
  endfunction

  function automatic bit is_store_f(input logic [3:0] f);
    is_store_f = (f == LSU_SW) || (f == LSU_SH) || (f == LSU_SB);
  endfunction

  function automatic logic [3:0] ref_be(input logic [3:0] f, input logic [31:0] a);
    int sz;
    int off;
    sz  = size_of(f);
    off = int'(a % 4);
    ref_be = 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [3:0] f, input logic [31:0] wd);
    case (size_of(f))
      1:       ref_wdata = (wd & 32'hFF) * 32'h0101_0101;
      2:       ref_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      default: ref_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] f, input logic [31:0] a, input logic [31:0] rd);
    int     off;
    longint val;
    off = int'(a % 4);
    val = 0;
    case (f)
      LSU_LW: val = longint'(rd);
      LSU_LH, LSU_LHU: begin
        val = longint'((rd >> ((off / 2) * 16)) & 32'hFFFF);
        if (f == LSU_LH && val >= 'h8000) val = val - 'h10000;
      end
      LSU_LB, LSU_LBU: begin
        val = longint'((rd >> (off * 8)) & 32'hFF);
        if (f == LSU_LB && val >= 'h80) val = val - 'h100;
      end
      default: val = 0;
    endcase
    ref_load = val[31:0];
  endfunction

  // ---------------- memory responder ----------------
  always @(posedge clk) begin
    #2;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = $urandom;
    if (!rst_n) begin
      armed = 1'b0;
    end else if (!armed) begin
      check_output("req_unexpected", 32'(data_req_o), 32'd0);
      data_gnt_i = 1'($urandom_range(0, 1));
    end else if (!phase) begin
      check_output("req_held", 32'(data_req_o), 32'd1);
      if (data_req_o) begin
        check_output("req_addr", data_addr_o, arm_addr);
        check_output("req_be", 32'(data_be_o), 32'(arm_be));
        check_output("req_wdata", data_wdata_o, arm_wdata);
        check_output("req_we", 32'(data_we_o), 32'(arm_we));
        if (gnt_left == 0) begin
          data_gnt_i = 1'b1;
          phase      = 1'b1;
        end else begin
          gnt_left--;
        end
      end
    end else begin
      check_output("req_after_gnt", 32'(data_req_o), 32'd0);
      data_gnt_i = 1'($urandom_range(0, 1));
      if (!drop) begin
        if (rv_left == 0) begin
          data_rvalid_i = 1'b1;
          data_rdata_i  = arm_rdata;
          armed         = 1'b0;
        end else begin
          rv_left--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t        e;
    logic [2:0]  exp_vec;
    bit          exp_stall;
    if (rst_n) begin
      exp_stall = (exp_q.size() > 0) && (cycle < exp_q[0].retire);
      check_output("stall", 32'(stall_o), 32'(exp_stall));
      if (done_o || misaligned_o || bus_error_o) begin
        if (exp_q.size() == 0) begin
          check_output("pulse_unexpected", 32'({done_o, misaligned_o, bus_error_o}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          exp_vec = (e.kind == K_DONE) ? 3'b100 : (e.kind == K_MIS) ? 3'b010 : 3'b001;
          check_output("pulse_kind", 32'({done_o, misaligned_o, bus_error_o}), 32'(exp_vec));
          check_output("load_data", load_data_o, e.load_data);
          check_output("retire_cycle", 32'(cycle), 32'(e.retire));
          if (e.kind == K_MIS) check_output("mis_req", 32'(data_req_o), 32'd0);
        end
      end else if (exp_q.size() > 0 && cycle > exp_q[0].retire) begin
        check_output("retire_missed", 32'(cycle), 32'(exp_q[0].retire));
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_all_zero(input string name);
    check_output({name, "_req_we_be"}, 32'({data_req_o, data_we_o, data_be_o}), 32'd0);
    check_output({name, "_addr"}, data_addr_o, 32'd0);
    check_output({name, "_wdata"}, data_wdata_o, 32'd0);
    check_output({name, "_flags"}, 32'({stall_o, done_o, misaligned_o, bus_error_o}), 32'd0);
    check_output({name, "_load"}, load_data_o, 32'd0);
  endtask

  // Called and returns at posedge+1; issues one access and waits for it.
  task automatic apply_stimulus(input logic [3:0] f, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int g, input int r, input bit drp);
    exp_t e;
    int   budget;
    valid_i    = 1'b1;
    lsu_func_i = f;
    addr_i     = a;
    wdata_i    = wd;
    if ((a % size_of(f)) != 0) begin
      e.kind      = K_MIS;
      e.load_data = '0;
      e.retire    = cycle;
    end else begin
      arm_addr  = a & 32'hFFFF_FFFC;
      arm_be    = ref_be(f, a);
      arm_wdata = is_store_f(f) ? ref_wdata(f, wd) : 32'd0;
      arm_we    = is_store_f(f);
      arm_rdata = rd;
      gnt_left  = g;
      rv_left   = r;
      drop      = drp;
      phase     = 1'b0;
      armed     = 1'b1;
      if (drp) begin
        e.kind      = K_BERR;
        e.load_data = '0;
        e.retire    = cycle + g + TIMEOUT;
      end else begin
        e.kind      = K_DONE;
        e.load_data = is_store_f(f) ? 32'd0 : ref_load(f, a, rd);
        e.retire    = cycle + g + 1 + r;
      end
    end
    exp_q.push_back(e);
    budget = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
      budget++;
      if (budget > 40) begin
        checks++;
        $display("[TB] FAIL txn_timeout: no retirement after %0d cycles, expected by cycle %0d", budget, e.retire);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        break;
      end
      // The unit is busy: these inputs must be ignored.
      valid_i    = 1'($urandom_range(0, 1));
      lsu_func_i = 4'($urandom_range(0, 8));
      addr_i     = $urandom;
      wdata_i    = $urandom;
    end
    valid_i    = 1'b0;
    lsu_func_i = LSU_NOP;
    armed      = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      valid_i    = 1'($urandom_range(0, 1));
      lsu_func_i = LSU_NOP;
      addr_i     = $urandom;
      wdata_i    = $urandom;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
  endtask

  initial begin
    logic [3:0]  f;
    logic [31:0] a;
    $display("[TB] start");
    valid_i    = 1'b1;
    lsu_func_i = LSU_LW;
    addr_i     = 32'h0000_0100;
    repeat (2) @(posedge clk);
    #3;
    check_all_zero("in_reset");
    valid_i = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus(LSU_LB,  32'h0000_1003, 32'h0, 32'h80FF_FF12, 0, 0, 1'b0);
    apply_stimulus(LSU_LHU, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 0, 1'b0);
    apply_stimulus(LSU_LH,  32'h0000_2002, 32'h0, 32'hBEEF_1234, 1, 1, 1'b0);
    apply_stimulus(LSU_SB,  32'h0000_3001, 32'h0000_00AB, $urandom, 3, 0, 1'b0);
    apply_stimulus(LSU_LW,  32'h0000_4002, 32'h0, 32'h0, 0, 0, 1'b0);
    apply_stimulus(LSU_SH,  32'h0000_4001, 32'h1234_5678, 32'h0, 0, 0, 1'b0);
    apply_stimulus(LSU_LW,  32'h0000_4000, 32'h0, 32'h0, 0, 0, 1'b1);
    apply_stimulus(LSU_LW,  32'h0000_4004, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
    apply_stimulus(LSU_SW,  32'h0000_5000, 32'hDEAD_BEEF, $urandom, 2, 3, 1'b0);
    apply_stimulus(LSU_LBU, 32'h0000_5002, 32'h0, 32'h0012_8000, 0, 3, 1'b0);
    apply_stimulus(LSU_SH,  32'h0000_5002, 32'h0000_A5C3, $urandom, 1, 0, 1'b0);
    idle_cycles(3);

    // Reset while waiting for a grant abandons the access.
    valid_i    = 1'b1;
    lsu_func_i = LSU_SB;
    addr_i     = 32'h0000_6001;
    wdata_i    = 32'h55;
    arm_addr   = 32'h0000_6000;
    arm_be     = 4'b0010;
    arm_wdata  = 32'h5555_5555;
    arm_we     = 1'b1;
    gnt_left   = 20;
    phase      = 1'b0;
    drop       = 1'b0;
    armed      = 1'b1;
    exp_q.push_back('{kind: K_DONE, load_data: 32'd0, retire: cycle + 30});
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    armed = 1'b0;
    valid_i    = 1'b1;
    lsu_func_i = LSU_LW;
    addr_i     = 32'h0000_7000;
    #2;
    check_all_zero("rst_mid");
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    rst_n   = 1'b1;
    idle_cycles(4);
    apply_stimulus(LSU_LW, 32'h0000_7000, 32'h0, 32'h0BAD_C0DE, 0, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      f = 4'($urandom_range(1, 8));
      a = $urandom;
      apply_stimulus(f, a, $urandom, $urandom, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end

    idle_cycles(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
